// File: rtl/wide_add_seq.sv
//------------------------------------------------------------------------------
// Module      : wide_add_seq
// Description : Wide unsigned adder that streams W-bit slices through an
//               external ripple adder, LSB slice first, one slice per cycle.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wide_add_seq #(
  parameter int W     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W*WORDS-1:0]   a_in,
  input  logic [W*WORDS-1:0]   b_in,
  input  logic                 c_in_in,
  output logic [W-1:0]         add_a,
  output logic [W-1:0]         add_b,
  output logic                 add_c_in,
  input  logic [W-1:0]         add_sum,
  input  logic                 add_c_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [W*WORDS-1:0]   sum_out,
  output logic                 c_out_out
);

  localparam int c_N     = W * WORDS;
  localparam int c_IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_IDX_W-1:0]   r_idx;
  logic                 r_carry;
  logic [c_N-1:0]       r_a;
  logic [c_N-1:0]       r_b;
  logic [c_N-1:0]       r_sum;
  logic                 r_c_out;
  logic                 r_in_ready;
  logic                 r_out_valid;

  logic [W-1:0]         w_add_a;
  logic [W-1:0]         w_add_b;
  logic                 w_add_c_in;

  // Slice mux toward the external adder; quiet (all zero) outside RUN.
  always_comb begin
    w_add_a    = '0;
    w_add_b    = '0;
    w_add_c_in = 1'b0;
    if (r_state == ST_RUN) begin
      w_add_c_in = r_carry;
      for (int i = 0; i < WORDS; i++) begin
        if (r_idx == c_IDX_W'(i)) begin
          w_add_a = r_a[i*W +: W];
          w_add_b = r_b[i*W +: W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_c_out     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a        <= a_in;
            r_b        <= b_in;
            r_carry    <= c_in_in;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= ST_RUN;
          end
        end

        ST_RUN: begin
          for (int i = 0; i < WORDS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
              r_sum[i*W +: W] <= add_sum;
            end
          end
          r_carry <= add_c_out;
          // Wrap idx on the last slice so it never exceeds WORDS-1.
          if (r_idx == c_LAST) begin
            r_idx       <= '0;
            r_c_out     <= add_c_out;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_idx       <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign add_a     = w_add_a;
  assign add_b     = w_add_b;
  assign add_c_in  = w_add_c_in;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum_out   = r_sum;
  assign c_out_out = r_c_out;

endmodule

`default_nettype wire

// File: tb/tb_wide_add_seq.sv
//------------------------------------------------------------------------------
// Module      : tb_wide_add_seq
// Description : Randomized self-checking bench for wide_add_seq with an
//               arithmetic reference model and a behavioural slice adder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_wide_add_seq;

  localparam int W     = 4;
  localparam int WORDS = 4;
  localparam int N     = W * WORDS;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   a_in;
  logic [N-1:0]   b_in;
  logic           c_in_in;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_c_in;
  logic [W-1:0]   add_sum;
  logic           add_c_out;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   sum_out;
  logic           c_out_out;

  int n_vec  = 0;
  int n_miss = 0;

  wide_add_seq #(.W(W), .WORDS(WORDS)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in_in   (c_in_in),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_c_in  (add_c_in),
    .add_sum   (add_sum),
    .add_c_out (add_c_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .c_out_out (c_out_out)
  );

  // External ripple adder stage
  assign {add_c_out, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_c_in};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Carry entering slice k for a+b+cin
  function automatic logic carry_into(input logic [N-1:0] a, input logic [N-1:0] b,
                                      input logic cin, input int k);
    longint unsigned m;
    longint unsigned s;
    if (k == 0) return cin;
    m = (64'd1 << (k * W)) - 1;
    s = (longint'(a) & m) + (longint'(b) & m) + longint'(cin);
    return s[k*W];
  endfunction

  task automatic wait_ready(input string tag);
    int t;
    t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (in_ready !== 1'b1) chk({tag, "_ready_timeout"}, 64'(in_ready), 64'd1);
  endtask

  // One full transaction; spam keeps in_valid high with junk operands
  // while busy, bp holds out_ready low for that many DONE cycles.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                        input int bp, input bit spam, input string tag);
    logic [N:0]   full;
    logic [N-1:0] held;
    full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    wait_ready(tag);
    out_ready = (bp == 0);
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    c_in_in   = cin;
    @(posedge clk);
    @(negedge clk);
    if (spam) begin
      a_in    = ~a;
      b_in    = 16'h5A5A;
      c_in_in = ~cin;
    end else begin
      in_valid = 1'b0;
    end
    for (int k = 0; k < WORDS; k++) begin
      chk($sformatf("%s_run%0d_in_ready", tag, k), 64'(in_ready), 64'd0);
      chk($sformatf("%s_run%0d_out_valid", tag, k), 64'(out_valid), 64'd0);
      chk($sformatf("%s_run%0d_add_a", tag, k), 64'(add_a), 64'((a >> (k * W)) & 16'hF));
      chk($sformatf("%s_run%0d_add_b", tag, k), 64'(add_b), 64'((b >> (k * W)) & 16'hF));
      chk($sformatf("%s_run%0d_add_c_in", tag, k), 64'(add_c_in), 64'(carry_into(a, b, cin, k)));
      @(negedge clk);
    end
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_sum"}, 64'(sum_out), 64'(full[N-1:0]));
    chk({tag, "_c_out"}, 64'(c_out_out), 64'(full[N]));
    chk({tag, "_done_add_a"}, 64'({add_c_in, add_a, add_b}), 64'd0);
    held = sum_out;
    for (int j = 0; j < bp; j++) begin
      @(negedge clk);
      chk($sformatf("%s_bp%0d_valid", tag, j), 64'(out_valid), 64'd1);
      chk($sformatf("%s_bp%0d_sum", tag, j), 64'(sum_out), 64'(full[N-1:0]));
      chk($sformatf("%s_bp%0d_in_ready", tag, j), 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_idle_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_idle_sum_kept"}, 64'({c_out_out, sum_out}), 64'(full));
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic         rc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    c_in_in   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_sum", 64'({c_out_out, sum_out}), 64'd0);
    chk("reset_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 64'(in_ready), 64'd1);
    chk("post_reset_adder", 64'({add_c_in, add_a, add_b}), 64'd0);

    run_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0, "carry8");
    run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, "ripple");
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b1, "allones_spam");
    run_op(16'h1357, 16'h2468, 1'b0, 3, 1'b0, "backpressure");

    // Reset during the second RUN cycle discards the operation
    wait_ready("rst_mid");
    in_valid = 1'b1;
    a_in     = 16'h1234;
    b_in     = 16'h1111;
    c_in_in  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_sum", 64'({c_out_out, sum_out}), 64'd0);
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_adder", 64'({add_c_in, add_a, add_b}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < WORDS + 2; j++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_quiet%0d", j), 64'({out_valid, in_ready}), 64'b01);
    end
    run_op(16'h1234, 16'h1111, 1'b0, 0, 1'b0, "after_rst");

    for (int t = 0; t < 24; t++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc, int'($urandom_range(0, 3)), 1'($urandom), $sformatf("rnd%0d", t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
